// File: rtl/cw_deserializer_pkg.sv
// Shared constants and state type for the (25,16) b=4 burst-code datapath:
// deserializer, matching serializer and decoder wrapper.
package cw_deserializer_pkg;

    localparam int CW_N     = 25;  // codeword length
    localparam int CW_K     = 16;  // payload bits
    localparam int CW_B     = 4;   // correctable burst length
    localparam int CW_CNT_W = 8;   // default statistics counter width

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } cw_state_e;

endpackage

// File: rtl/cw_deserializer_if.sv
// Serial-in / codeword-out bundle; slave is the deserializer side, master the
// channel plus downstream decoder side.
interface cw_deserializer_if
    import cw_deserializer_pkg::*;
#(
    parameter int N     = CW_N,
    parameter int CNT_W = CW_CNT_W
);
    logic             rx_bit;
    logic             rx_valid;
    logic             rx_sof;
    logic [N-1:0]     cw_data;
    logic             cw_valid;
    logic             cw_ready;
    logic             stat_clr;
    logic             ovf;
    logic [CNT_W-1:0] drop_cnt;
    logic             align_err;

    modport slave (
        input  rx_bit, rx_valid, rx_sof, cw_ready, stat_clr,
        output cw_data, cw_valid, ovf, drop_cnt, align_err
    );

    modport master (
        output rx_bit, rx_valid, rx_sof, cw_ready, stat_clr,
        input  cw_data, cw_valid, ovf, drop_cnt, align_err
    );
endinterface

// File: rtl/cw_fifo2.sv
// Two-entry FIFO holding completed codewords; head shows the oldest entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cw_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         wr_en;
    logic         rd_en;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so head reads zero coming out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) rd_ptr <= ~rd_ptr;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cw_deserializer.sv
// Assembles serial bits into N-bit codewords framed by rx_sof, buffers them in
// a 2-entry FIFO and keeps drop statistics for words lost to back-pressure.
module cw_deserializer
    import cw_deserializer_pkg::*;
#(
    parameter int N     = CW_N,
    parameter int CNT_W = CW_CNT_W
) (
    input logic              clk,
    input logic              rst_n,
    cw_deserializer_if.slave bus
);
    localparam int               IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    cw_state_e        state;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     shreg;
    logic             align_err_q;
    logic             ovf_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic             sof_bit;
    logic             data_bit;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [N-1:0]     push_data;

    assign sof_bit  = bus.rx_valid && bus.rx_sof;
    assign data_bit = bus.rx_valid && !bus.rx_sof;

    // The last bit goes straight into the FIFO so the word shows one cycle later.
    assign push      = (state == COLLECT) && data_bit && (idx == LAST_IDX);
    assign push_data = {bus.rx_bit, shreg[N-2:0]};
    assign pop       = !empty && bus.cw_ready;
    assign drop      = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            idx         <= '0;
            shreg       <= '0;
            align_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read below sees pre-edge state.
            align_err_q <= 1'b0;
            if (sof_bit) begin
                shreg[0]    <= bus.rx_bit;
                idx         <= IDX_W'(1);
                state       <= COLLECT;
                align_err_q <= (state == COLLECT);
            end else if (data_bit) begin
                if (state == HUNT) begin
                    align_err_q <= 1'b1;
                end else begin
                    shreg[idx] <= bus.rx_bit;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= HUNT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            end
        end
    end

    // A clear wins over a coincident drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (bus.stat_clr) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != CNT_MAX) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    cw_fifo2 #(.W(N)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (bus.cw_data)
    );

    assign bus.cw_valid  = !empty;
    assign bus.align_err = align_err_q;
    assign bus.ovf       = ovf_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_cw_deserializer.sv
// Directed bench for cw_deserializer: framing, latency, back-pressure, drops,
// statistics saturation/clear and reset behaviour.
module tb_cw_deserializer;
    import cw_deserializer_pkg::*;

    localparam int N     = CW_N;
    localparam int CNT_W = 8;

    localparam logic [N-1:0] W_A = 25'h0F0F0F1;
    localparam logic [N-1:0] W_B = 25'h1555555;
    localparam logic [N-1:0] W_C = 25'h0AAAAAA;
    localparam logic [N-1:0] W_D = 25'h1C3A5E7;
    localparam logic [N-1:0] W_X = 25'h0123456;
    localparam logic [N-1:0] W_Y = 25'h13579BD;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cw_deserializer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    cw_deserializer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Negedge monitor: delivered words, valid/align counts, hold stability.
    logic [N-1:0] got_q [$];
    int           valid_cycles = 0;
    int           align_pulses = 0;
    logic         held = 1'b0;
    logic [N-1:0] held_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held && bus.cw_valid) begin
                checks++;
                if (bus.cw_data !== held_data) begin
                    errors++;
                    $display("FAIL stable_data actual=%h required=%h", bus.cw_data, held_data);
                end
            end
            if (bus.cw_valid) valid_cycles++;
            if (bus.align_err) align_pulses++;
            if (bus.cw_valid && bus.cw_ready) got_q.push_back(bus.cw_data);
            held      = bus.cw_valid && !bus.cw_ready;
            held_data = bus.cw_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input logic v, input logic b, input logic s);
        bus.rx_valid = v;
        bus.rx_bit   = b;
        bus.rx_sof   = s;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) tick(1'b1, w[i], i == 0);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.rx_bit   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b0;
        bus.cw_ready = 1'b0;
        bus.stat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.cw_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", bus.cw_valid); end
        checks++; if (bus.cw_data !== '0) begin errors++; $display("FAIL reset_data actual=%h required=0", bus.cw_data); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b required=0", bus.ovf); end
        checks++; if (bus.drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt actual=%0d required=0", bus.drop_cnt); end
        checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err actual=%b required=0", bus.align_err); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single();
        logic [N-1:0] val;
        logic [N-1:0] pat;
        val = 25'h1A2B3C4;
        for (int i = 0; i < N; i++) pat[i] = val[N-1-i];
        bus.cw_ready = 1'b1;
        got_q.delete();
        valid_cycles = 0;
        for (int i = 0; i < N; i++) tick(1'b1, pat[i], i == 0);
        checks++; if (bus.cw_valid !== 1'b1) begin errors++; $display("FAIL single_latency actual=%b required=1", bus.cw_valid); end
        checks++; if (bus.cw_data !== pat) begin errors++; $display("FAIL single_data actual=%h required=%h", bus.cw_data, pat); end
        idle(3);
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL single_valid_cycles actual=%0d required=1", valid_cycles); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count actual=%0d required=1", got_q.size()); end
        checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== pat) begin errors++; $display("FAIL single_popped actual=%h required=%h", (got_q.size() > 0 ? got_q[0] : 'x), pat); end
    endtask

    task automatic test_overflow();
        bus.cw_ready = 1'b0;
        got_q.delete();
        send_word(W_A);
        send_word(W_B);
        send_word(W_C);
        checks++; if (bus.cw_valid !== 1'b1 || bus.cw_data !== W_A) begin errors++; $display("FAIL ovf_head actual=%b/%h required=1/%h", bus.cw_valid, bus.cw_data, W_A); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag actual=%b required=1", bus.ovf); end
        checks++; if (bus.drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop_cnt actual=%0d required=1", bus.drop_cnt); end
        bus.cw_ready = 1'b1;
        idle(1);
        checks++; if (bus.cw_valid !== 1'b1 || bus.cw_data !== W_B) begin errors++; $display("FAIL ovf_second actual=%b/%h required=1/%h", bus.cw_valid, bus.cw_data, W_B); end
        idle(1);
        checks++; if (bus.cw_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained actual=%b required=0", bus.cw_valid); end
        checks++; if (got_q.size() != 2 || got_q[0] !== W_A || got_q[1] !== W_B) begin errors++; $display("FAIL ovf_order actual_count=%0d required=2 (A then B)", got_q.size()); end
        bus.stat_clr = 1'b1;
        idle(1);
        bus.stat_clr = 1'b0;
        checks++; if (bus.ovf !== 1'b0 || bus.drop_cnt !== '0) begin errors++; $display("FAIL ovf_clear actual=%b/%0d required=0/0", bus.ovf, bus.drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        bus.cw_ready = 1'b0;
        got_q.delete();
        send_word(W_A);
        send_word(W_B);
        for (int i = 0; i < N - 1; i++) tick(1'b1, W_C[i], i == 0);
        bus.cw_ready = 1'b1;
        tick(1'b1, W_C[N-1], 1'b0);
        checks++; if (bus.cw_valid !== 1'b1 || bus.cw_data !== W_B) begin errors++; $display("FAIL fullpp_head actual=%b/%h required=1/%h", bus.cw_valid, bus.cw_data, W_B); end
        checks++; if (bus.ovf !== 1'b0 || bus.drop_cnt !== '0) begin errors++; $display("FAIL fullpp_nodrop actual=%b/%0d required=0/0", bus.ovf, bus.drop_cnt); end
        idle(3);
        checks++; if (got_q.size() != 3 || got_q[0] !== W_A || got_q[1] !== W_B || got_q[2] !== W_C) begin errors++; $display("FAIL fullpp_order actual_count=%0d required=3 (A,B,C)", got_q.size()); end
    endtask

    task automatic test_misalign();
        bus.cw_ready = 1'b1;
        got_q.delete();
        align_pulses = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, W_X[i], i == 0);
        tick(1'b1, W_Y[0], 1'b1);
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse actual=%b required=1", bus.align_err); end
        for (int i = 1; i < N; i++) tick(1'b1, W_Y[i], 1'b0);
        idle(3);
        checks++; if (align_pulses != 1) begin errors++; $display("FAIL misalign_count actual=%0d required=1", align_pulses); end
        checks++; if (got_q.size() != 1 || got_q[0] !== W_Y) begin errors++; $display("FAIL misalign_word actual_count=%0d required=1 (Y)", got_q.size()); end
    endtask

    task automatic test_gaps();
        bus.cw_ready = 1'b1;
        got_q.delete();
        align_pulses = 0;
        for (int i = 0; i < N; i++) begin
            tick(1'b1, W_D[i], i == 0);
            idle(i % 3);
        end
        idle(2);
        checks++; if (got_q.size() != 1 || got_q[0] !== W_D || align_pulses != 0) begin errors++; $display("FAIL gaps_word actual_count=%0d align=%0d required=1/0", got_q.size(), align_pulses); end
    endtask

    task automatic test_hunt_noise();
        got_q.delete();
        align_pulses = 0;
        valid_cycles = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL hunt_pulse actual=%b required=1", bus.align_err); end
        idle(1);
        checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL hunt_pulse_end actual=%b required=0", bus.align_err); end
        checks++; if (align_pulses != 5) begin errors++; $display("FAIL hunt_count actual=%0d required=5", align_pulses); end
        checks++; if (valid_cycles != 0) begin errors++; $display("FAIL hunt_valid actual=%0d required=0", valid_cycles); end
    endtask

    task automatic test_saturation();
        bus.cw_ready = 1'b0;
        got_q.delete();
        send_word(W_A);
        send_word(W_B);
        repeat (300) send_word(W_C);
        checks++; if (bus.drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop_cnt actual=%0d required=255", bus.drop_cnt); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf actual=%b required=1", bus.ovf); end
        bus.stat_clr = 1'b1;
        idle(1);
        bus.stat_clr = 1'b0;
        checks++; if (bus.ovf !== 1'b0 || bus.drop_cnt !== '0) begin errors++; $display("FAIL sat_clear actual=%b/%0d required=0/0", bus.ovf, bus.drop_cnt); end
        for (int i = 0; i < N - 1; i++) tick(1'b1, W_C[i], i == 0);
        bus.stat_clr = 1'b1;
        tick(1'b1, W_C[N-1], 1'b0);
        bus.stat_clr = 1'b0;
        checks++; if (bus.ovf !== 1'b0 || bus.drop_cnt !== '0) begin errors++; $display("FAIL clr_wins actual=%b/%0d required=0/0", bus.ovf, bus.drop_cnt); end
        send_word(W_C);
        checks++; if (bus.ovf !== 1'b1 || bus.drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_after_clr actual=%b/%0d required=1/1", bus.ovf, bus.drop_cnt); end
        bus.cw_ready = 1'b1;
        bus.stat_clr = 1'b1;
        idle(3);
        bus.stat_clr = 1'b0;
        checks++; if (bus.cw_valid !== 1'b0) begin errors++; $display("FAIL sat_drain actual=%b required=0", bus.cw_valid); end
    endtask

    task automatic test_reset_mid();
        bus.cw_ready = 1'b0;
        got_q.delete();
        send_word(W_A);
        for (int i = 0; i < 12; i++) tick(1'b1, W_B[i], i == 0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.cw_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid actual=%b required=0", bus.cw_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.cw_ready = 1'b1;
        align_pulses = 0;
        tick(1'b1, 1'b1, 1'b0);
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL rstmid_needs_sof actual=%b required=1", bus.align_err); end
        send_word(W_D);
        idle(3);
        checks++; if (got_q.size() != 1 || got_q[0] !== W_D) begin errors++; $display("FAIL rstmid_word actual_count=%0d required=1 (D)", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_misalign();
        test_gaps();
        test_hunt_noise();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cw_deserializer.md
CW_DESERIALIZER -- requirements
Module: cw_deserializer

Interface
REQ-001 SHALL have parameter N, default 25, meaning codeword length in bits for the (25,16) b=4 burst code.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the dropped-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_bit, input, 1, serial channel bit.
REQ-006 SHALL have port rx_valid, input, 1, which qualifies rx_bit.
REQ-007 SHALL have port rx_sof, input, 1, which marks codeword bit 0 and is meaningful only with rx_valid.
REQ-008 SHALL have port cw_data, output, N (index 0 to N-1), the assembled codeword for the downstream decoder.
REQ-009 SHALL have port cw_valid, output, 1, meaning cw_data holds a complete word.
REQ-010 SHALL have port cw_ready, input, 1, downstream accept.
REQ-011 SHALL have port stat_clr, input, 1, a synchronous clear of the statistics.
REQ-012 SHALL have port ovf, output, 1, a sticky flag meaning a word was dropped.
REQ-013 SHALL have port drop_cnt, output, CNT_W, a saturating count of dropped words.
REQ-014 SHALL have port align_err, output, 1, a one-cycle pulse flagging a framing violation.

Function
REQ-015 SHALL implement a two-state FSM, HUNT and COLLECT, with a bit index idx running 0..N-1.
REQ-016 In HUNT, rx_valid&&rx_sof SHALL store rx_bit at position 0, set idx=1, and move the FSM to COLLECT.
REQ-017 In HUNT, rx_valid&&!rx_sof SHALL discard the bit and pulse align_err the next cycle.
REQ-018 In COLLECT, rx_valid&&!rx_sof SHALL store rx_bit at position idx and increment idx.
REQ-019 In COLLECT, the bit stored at idx=N-1 SHALL complete the word, push it to the output buffer, and return the FSM to HUNT.
REQ-020 In COLLECT, rx_valid&&rx_sof SHALL discard the partial word, pulse align_err, and restart at position 0 with idx=1.
REQ-021 Bit order SHALL be first serial bit to cw_data[0] and last to cw_data[N-1].
REQ-022 Cycles with rx_valid=0 SHALL hold all assembly state, with no timeout.
REQ-023 The output buffer SHALL be a 2-entry FIFO and cw_data SHALL show its head entry.
REQ-024 cw_valid SHALL equal buffer non-empty, and a pop SHALL occur on cw_valid&&cw_ready.
REQ-025 A completed word SHALL appear on cw_valid in the cycle after its last bit is sampled, giving 1-cycle latency when the buffer is empty.
REQ-026 Once cw_valid is asserted, cw_data SHALL be stable until the pop.
REQ-027 A push and a pop in the same cycle SHALL both be accepted, including when the buffer is full.
REQ-028 A push while the buffer is full with no pop SHALL drop the new word, set ovf, and increment drop_cnt, saturating at 2^CNT_W-1.
REQ-029 stat_clr SHALL zero ovf and drop_cnt next cycle; a drop coincident with stat_clr SHALL NOT be recorded.
REQ-030 The block SHALL sustain 1 bit/cycle indefinitely when cw_ready is held high.

Reset
REQ-031 On rst_n low, the FSM SHALL be HUNT, idx=0, the buffer empty, cw_valid=0, cw_data=0, ovf=0, drop_cnt=0, and align_err=0.
REQ-032 Reset mid-word SHALL discard the partial word and all buffered words.
REQ-033 After reset release, the first accepted bit SHALL require rx_sof.

Structure
REQ-034 A shared package SHALL hold N=25, K=16, B=4, and the FSM state enum, for reuse by the matching serializer and the decoder wrapper.
REQ-035 The 2-entry FIFO SHALL be the sub-module cw_fifo2, with push, pop, full, empty and head-data ports and a width parameter.

Verification
REQ-036 Scenario: after reset, send 25 bits of 0x1A2B3C4 MSB-aligned (pattern c[0]=1, rest per value) with rx_sof on the first bit and cw_ready=1 -> cw_valid high for exactly 1 cycle starting the cycle after bit 24, with cw_data equal to the sent pattern.
REQ-037 Scenario: cw_ready=0 and 3 back-to-back words A, B, C -> A and B are held, C is dropped, ovf=1 and drop_cnt=1; raising cw_ready then pops A and then B.
REQ-038 Scenario: rx_sof reasserted at bit 10 of a word -> align_err pulses once, the next complete 25 bits are delivered, and no partial word is output.
REQ-039 Scenario: 5 bits without rx_sof in HUNT -> 5 align_err pulses and cw_valid stays 0.
REQ-040 Scenario: 300 forced drops -> drop_cnt saturates at 255; stat_clr then gives drop_cnt=0 and ovf=0.
REQ-041 Scenario: rst_n low at bit 12 with one word buffered -> cw_valid=0 immediately, and a full word sent after release is delivered intact.
